// File: rtl/axi_ram_slave.sv
// AXI4 64-bit RAM slave with independent read/write FSMs and per-beat decode errors.
// Optional random back-pressure when AXI_RAM_LFSR_STALL_EN is defined.
module axi_ram_slave #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          MEM_WORDS_LOG2 = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  SAXI_awid,
    input  logic [31:0] SAXI_awaddr,
    input  logic [7:0]  SAXI_awlen,
    input  logic [2:0]  SAXI_awsize,
    input  logic [1:0]  SAXI_awburst,
    input  logic        SAXI_awvalid,
    output logic        SAXI_awready,
    input  logic [63:0] SAXI_wdata,
    input  logic [7:0]  SAXI_wstrb,
    input  logic        SAXI_wlast,
    input  logic        SAXI_wvalid,
    output logic        SAXI_wready,
    output logic [3:0]  SAXI_bid,
    output logic [1:0]  SAXI_bresp,
    output logic        SAXI_bvalid,
    input  logic        SAXI_bready,
    input  logic [3:0]  SAXI_arid,
    input  logic [31:0] SAXI_araddr,
    input  logic [7:0]  SAXI_arlen,
    input  logic [2:0]  SAXI_arsize,
    input  logic [1:0]  SAXI_arburst,
    input  logic        SAXI_arvalid,
    output logic        SAXI_arready,
    output logic [3:0]  SAXI_rid,
    output logic [63:0] SAXI_rdata,
    output logic [1:0]  SAXI_rresp,
    output logic        SAXI_rlast,
    output logic        SAXI_rvalid,
    input  logic        SAXI_rready
);

    localparam int AW = MEM_WORDS_LOG2;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [63:0] mem [1<<AW];

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [7:0] len);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic stall;
`ifdef AXI_RAM_LFSR_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    logic [15:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign stall = 1'b0;
`endif

    // ---------------- read side ----------------
    r_state_t    r_state, r_state_next;
    logic [31:0] r_addr, r_nxt, rd_addr, rd_off;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        ar_hs, r_hs, launch, launch_last, rd_ok;
    logic [AW-1:0] rd_idx;

    always_comb begin
        r_state_next = r_state;
        SAXI_arready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                SAXI_arready = !reset && !stall;
                if (SAXI_arvalid && SAXI_arready) r_state_next = R_BURST;
            end
            R_BURST: if (SAXI_rvalid && SAXI_rready && SAXI_rlast) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // A beat is launched on AR acceptance, after a non-final handshake, or when a stalled launch resumes.
    always_comb begin
        ar_hs       = SAXI_arvalid && SAXI_arready;
        r_hs        = SAXI_rvalid && SAXI_rready;
        r_nxt       = next_addr(r_addr, r_size, r_burst, r_len);
        rd_addr     = ar_hs ? SAXI_araddr : (r_hs ? r_nxt : r_addr);
        rd_off      = rd_addr - BASE_ADDR;
        rd_ok       = (rd_off >> (AW + 3)) == 32'd0;
        rd_idx      = rd_off[AW+2:3];
        launch      = ar_hs || ((r_state == R_BURST) && !stall &&
                                (r_hs ? !SAXI_rlast : !SAXI_rvalid));
        launch_last = ar_hs ? (SAXI_arlen == 8'd0)
                            : ((r_hs ? r_cnt + 8'd1 : r_cnt) == r_len);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            SAXI_rvalid <= 1'b0;
            SAXI_rlast  <= 1'b0;
            SAXI_rid    <= '0;
            SAXI_rresp  <= '0;
            SAXI_rdata  <= '0;
        end else begin
            r_state <= r_state_next;
            if (ar_hs) begin
                r_addr   <= SAXI_araddr;
                r_len    <= SAXI_arlen;
                r_size   <= SAXI_arsize;
                r_burst  <= SAXI_arburst;
                r_cnt    <= 8'd0;
                SAXI_rid <= SAXI_arid;
            end else if (r_hs && !SAXI_rlast) begin
                r_addr <= r_nxt;
                r_cnt  <= r_cnt + 8'd1;
            end
            if (launch) begin
                SAXI_rvalid <= 1'b1;
                SAXI_rlast  <= launch_last;
                SAXI_rdata  <= rd_ok ? mem[rd_idx] : 64'd0;
                SAXI_rresp  <= rd_ok ? 2'b00 : 2'b11;
            end else if (r_hs) begin
                SAXI_rvalid <= 1'b0;
                SAXI_rlast  <= 1'b0;
            end
        end
    end

    // ---------------- write side ----------------
    w_state_t    w_state, w_state_next;
    logic [31:0] w_addr, w_nxt, wr_off;
    logic [7:0]  w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst, beat_resp, w_worst;
    logic        aw_hs, w_hs, w_end, wr_ok, last_err;
    logic [AW-1:0] wr_idx;

    always_comb begin
        w_state_next = w_state;
        SAXI_awready = 1'b0;
        SAXI_wready  = 1'b0;
        SAXI_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                SAXI_awready = !reset && !stall;
                if (SAXI_awvalid && SAXI_awready) w_state_next = W_DATA;
            end
            W_DATA: begin
                SAXI_wready = !stall;
                if (SAXI_wvalid && SAXI_wready && w_end) w_state_next = W_RESP;
            end
            W_RESP: begin
                SAXI_bvalid = 1'b1;
                if (SAXI_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // bresp accumulates the worst beat response plus SLVERR when wlast and the beat count disagree.
    always_comb begin
        aw_hs     = SAXI_awvalid && SAXI_awready;
        w_hs      = SAXI_wvalid && SAXI_wready;
        w_end     = SAXI_wlast || (w_cnt == w_len);
        w_nxt     = next_addr(w_addr, w_size, w_burst, w_len);
        wr_off    = w_addr - BASE_ADDR;
        wr_ok     = (wr_off >> (AW + 3)) == 32'd0;
        wr_idx    = wr_off[AW+2:3];
        beat_resp = wr_ok ? 2'b00 : 2'b11;
        last_err  = SAXI_wlast != (w_cnt == w_len);
        w_worst   = worst(worst(SAXI_bresp, beat_resp), last_err ? 2'b10 : 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state    <= W_IDLE;
            w_addr     <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_size     <= '0;
            w_burst    <= '0;
            SAXI_bid   <= '0;
            SAXI_bresp <= '0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                w_addr     <= SAXI_awaddr;
                w_len      <= SAXI_awlen;
                w_size     <= SAXI_awsize;
                w_burst    <= SAXI_awburst;
                w_cnt      <= 8'd0;
                SAXI_bid   <= SAXI_awid;
                SAXI_bresp <= 2'b00;
            end else if (w_hs) begin
                w_addr     <= w_nxt;
                w_cnt      <= w_cnt + 8'd1;
                SAXI_bresp <= w_worst;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_hs && wr_ok) begin
            for (int b = 0; b < 8; b++) begin
                if (SAXI_wstrb[b]) mem[wr_idx][8*b +: 8] <= SAXI_wdata[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rd_off[2:0], wr_off[2:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: reference memory model, expected R beats queued at AR time.
module tb_axi_ram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] WIN  = 32'h0008_0000;

    logic        clock, reset;
    logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;  logic [7:0] wstrb;   logic wlast, wvalid, wready;
    logic [3:0]  bid;    logic [1:0] bresp;   logic bvalid, bready;
    logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;    logic [63:0] rdata;  logic [1:0] rresp; logic rlast, rvalid, rready;

    axi_ram_slave dut (
        .clock(clock), .reset(reset),
        .SAXI_awid(awid), .SAXI_awaddr(awaddr), .SAXI_awlen(awlen), .SAXI_awsize(awsize),
        .SAXI_awburst(awburst), .SAXI_awvalid(awvalid), .SAXI_awready(awready),
        .SAXI_wdata(wdata), .SAXI_wstrb(wstrb), .SAXI_wlast(wlast), .SAXI_wvalid(wvalid),
        .SAXI_wready(wready),
        .SAXI_bid(bid), .SAXI_bresp(bresp), .SAXI_bvalid(bvalid), .SAXI_bready(bready),
        .SAXI_arid(arid), .SAXI_araddr(araddr), .SAXI_arlen(arlen), .SAXI_arsize(arsize),
        .SAXI_arburst(arburst), .SAXI_arvalid(arvalid), .SAXI_arready(arready),
        .SAXI_rid(rid), .SAXI_rdata(rdata), .SAXI_rresp(rresp), .SAXI_rlast(rlast),
        .SAXI_rvalid(rvalid), .SAXI_rready(rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] model [int unsigned];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic bit tb_in_win(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < WIN);
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a);
        int unsigned k;
        if (!tb_in_win(a)) return 64'h0;
        k = (a - BASE) >> 3;
        if (model.exists(k)) return model[k];
        return 64'h0;
    endfunction

    function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [7:0] len);
        logic [31:0] step, total, lo, n;
        step  = 32'd1 << size;
        total = (32'(len) + 32'd1) * step;
        if (burst == 2'b00) return a;
        n = a + step;
        if (burst == 2'b10) begin
            lo = a - (a % total);
            if (n >= lo + total) n = lo;
        end
        return n;
    endfunction

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input bit toggle,
                           input string tag);
        logic [31:0] a;
        beat_t       b;
        int          cyc;
        bit          done;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            b.data = model_read(a);
            b.resp = tb_in_win(a) ? 2'b00 : 2'b11;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            a = tb_next(a, size, burst, len);
        end
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        cyc = 0;
        @(negedge clock);
        while (arready !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
        if (cyc >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL %s ar_timeout: arready=%b required 1", tag, arready);
        end
        @(posedge clock); #1;
        arvalid = 1'b0;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            @(negedge clock);
            if (cyc == 0) begin
                n_cmp++;
                if (rvalid !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s first_beat_latency: rvalid=%b required 1", tag, rvalid);
                end
            end
            if (rvalid === 1'b1 && exp_q.size() > 0) begin
                b = exp_q[0];
                n_cmp++;
                if (rdata !== b.data || rresp !== b.resp || rlast !== b.last || rid !== id) begin
                    n_err++;
                    $display("FAIL %s r_beat: got data=%h resp=%b last=%b id=%h required data=%h resp=%b last=%b id=%h",
                             tag, rdata, rresp, rlast, rid, b.data, b.resp, b.last, id);
                end
                if (rready) begin
                    void'(exp_q.pop_front());
                    if (b.last) done = 1'b1;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        rready = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s r_timeout: %0d beats still expected, required 0", tag, exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        n_cmp++;
        if (arready !== 1'b1) begin
            n_err++;
            $display("FAIL %s arready_return: arready=%b required 1", tag, arready);
        end
        @(posedge clock); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input logic [63:0] data [16],
                            input logic [7:0] strb, input int last_idx, input logic [1:0] exp_bresp,
                            input string tag);
        logic [31:0] a;
        logic [63:0] w;
        int          nbeats, cyc;
        nbeats = (last_idx < int'(len)) ? last_idx + 1 : int'(len) + 1;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            if (tb_in_win(a)) begin
                w = model_read(a);
                for (int bb = 0; bb < 8; bb++) if (strb[bb]) w[8*bb +: 8] = data[i][8*bb +: 8];
                model[(a - BASE) >> 3] = w;
            end
            a = tb_next(a, size, burst, len);
        end
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        cyc = 0;
        @(negedge clock);
        while (awready !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
        if (cyc >= 50) begin
            n_cmp++; n_err++;
            $display("FAIL %s aw_timeout: awready=%b required 1", tag, awready);
        end
        @(posedge clock); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = data[i]; wstrb = strb; wlast = (i == last_idx);
            @(negedge clock);
            if (i == 0) begin
                n_cmp++;
                if (wready !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s wready_latency: wready=%b required 1", tag, wready);
                end
            end
            cyc = 0;
            while (wready !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
            @(posedge clock); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== exp_bresp || bid !== id) begin
            n_err++;
            $display("FAIL %s b_resp: bvalid=%b bresp=%b bid=%h required 1 %b %h",
                     tag, bvalid, bresp, bid, exp_bresp, id);
        end
        @(posedge clock); #1;
        bready = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL %s b_hold: bvalid=%b required 1", tag, bvalid);
        end
        @(posedge clock); #1;
        bready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL %s b_done: awready=%b bvalid=%b required 1 0", tag, awready, bvalid);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        n_cmp++;
        if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0 ||
            rid !== 4'h0 || rresp !== 2'b00 || rdata !== 64'h0 || bid !== 4'h0 || bresp !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values: ar/aw/w/rv/rl/bv=%b rid=%h rresp=%b rdata=%h bid=%h bresp=%b required all zero",
                     {arready, awready, wready, rvalid, rlast, bvalid}, rid, rresp, rdata, bid, bresp);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: arready=%b awready=%b wready=%b required 1 1 0", arready, awready, wready);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        logic [63:0] d [16];
        d[0] = 64'h1122_3344_5566_7788;
        do_write(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h3, d, 8'hFF, 0, 2'b00, "single_wr");
        do_read(32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h5, 1'b0, "single_rd");
    endtask

    task automatic test_incr_burst();
        logic [63:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 64'(i) * 64'h0101_0101_0101_0101;
        do_write(32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'h7, d, 8'hFF, 7, 2'b00, "incr_wr");
        do_read(32'h8000_0040, 8'd7, 3'd3, 2'b01, 4'h9, 1'b1, "incr_rd_toggle");
        do_read(32'h8000_0040, 8'd3, 3'd2, 2'b01, 4'h2, 1'b0, "narrow_rd");
        do_read(32'h8000_0048, 8'd1, 3'd3, 2'b11, 4'h4, 1'b0, "reserved_burst_rd");
    endtask

    task automatic test_wrap();
        logic [63:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 64'hA0A0_0000_0000_0000 | 64'(i + 1);
        do_write(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h1, d, 8'hFF, 3, 2'b00, "wrap_prep");
        do_read(32'h8000_0010, 8'd3, 3'd3, 2'b10, 4'hA, 1'b0, "wrap_rd");
    endtask

    task automatic test_strobe();
        logic [63:0] d [16];
        d[0] = 64'h0;
        do_write(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, d, 8'hFF, 0, 2'b00, "strb_zero");
        d[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h0, d, 8'h0F, 0, 2'b00, "strb_partial");
        do_read(32'h8000_0100, 8'd0, 3'd3, 2'b01, 4'h6, 1'b0, "strb_rd");
    endtask

    task automatic test_fixed();
        logic [63:0] d [16];
        d[0] = 64'h1; d[1] = 64'h2; d[2] = 64'hDEAD_BEEF_0000_0003;
        do_write(32'h8000_0200, 8'd2, 3'd3, 2'b00, 4'hB, d, 8'hFF, 2, 2'b00, "fixed_wr");
        do_read(32'h8000_0200, 8'd1, 3'd3, 2'b00, 4'hC, 1'b0, "fixed_rd");
    endtask

    task automatic test_decerr();
        logic [63:0] d [16];
        do_read(32'h7FFF_FFF8, 8'd1, 3'd3, 2'b00, 4'hD, 1'b0, "decerr_below_rd");
        d[0] = 64'hCAFE_F00D_1234_5678; d[1] = 64'h5555_AAAA_5555_AAAA;
        do_write(BASE + WIN - 32'd8, 8'd1, 3'd3, 2'b01, 4'hE, d, 8'hFF, 1, 2'b11, "decerr_cross_wr");
        do_read(BASE + WIN - 32'd8, 8'd1, 3'd3, 2'b01, 4'hE, 1'b0, "decerr_cross_rd");
    endtask

    task automatic test_wlast_errors();
        logic [63:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 64'h7700_0000_0000_0000 | 64'(i);
        do_write(32'h8000_0300, 8'd3, 3'd3, 2'b01, 4'h8, d, 8'hFF, 0, 2'b10, "early_wlast");
        do_write(32'h8000_0340, 8'd1, 3'd3, 2'b01, 4'h8, d, 8'hFF, 99, 2'b10, "missing_wlast");
        do_read(32'h8000_0300, 8'd1, 3'd3, 2'b01, 4'h1, 1'b0, "early_wlast_rd");
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        araddr = 32'h8000_0040; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arid = 4'hF;
        arvalid = 1'b1;
        cyc = 0;
        @(negedge clock);
        while (arready !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
        @(posedge clock); #1;
        arvalid = 1'b0; rready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++;
            if (rvalid !== 1'b1 || rdata !== model_read(32'h8000_0040 + 32'(8 * k))) begin
                n_err++;
                $display("FAIL midreset_beat%0d: rvalid=%b rdata=%h required 1 %h",
                         k, rvalid, rdata, model_read(32'h8000_0040 + 32'(8 * k)));
            end
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        n_cmp++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || arready !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_abort: rvalid=%b rlast=%b arready=%b required 0 0 0", rvalid, rlast, arready);
        end
        @(posedge clock); #1;
        reset = 1'b0; rready = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release: arready=%b rvalid=%b required 1 0", arready, rvalid);
        end
        @(posedge clock); #1;
        do_read(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'h2, 1'b0, "post_reset_rd");
    endtask

    initial begin
        reset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_incr_burst();
        test_wrap();
        test_strobe();
        test_fixed();
        test_decerr();
        test_wlast_errors();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI4 slave memory with a 64-bit data path; sits directly downstream of the CPU top wrapper's `MAXI_*` master port in the difftest simulation top. It serves instruction fetch, data access and cache-line bursts. Read and write channels are fully independent, and the block returns decode errors for addresses outside its window.

## Interface
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0.
- `MEM_WORDS_LOG2`, 16, log2 of memory depth in 64-bit words (default 512 KiB).
- `LFSR_SEED`, 16'hACE1, stall LFSR seed (used only under the macro).
- `clock` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- AW channel:
  - `SAXI_awid` in 4, `SAXI_awaddr` in 32, `SAXI_awlen` in 8, `SAXI_awsize` in 3, `SAXI_awburst` in 2.
  - `SAXI_awvalid` in 1, `SAXI_awready` out 1.
- W channel: `SAXI_wdata` in 64, `SAXI_wstrb` in 8, `SAXI_wlast` in 1, `SAXI_wvalid` in 1, `SAXI_wready` out 1.
- B channel: `SAXI_bid` out 4, `SAXI_bresp` out 2, `SAXI_bvalid` out 1, `SAXI_bready` in 1.
- AR channel:
  - `SAXI_arid` in 4, `SAXI_araddr` in 32, `SAXI_arlen` in 8, `SAXI_arsize` in 3, `SAXI_arburst` in 2.
  - `SAXI_arvalid` in 1, `SAXI_arready` out 1.
- R channel:
  - `SAXI_rid` out 4, `SAXI_rdata` out 64, `SAXI_rresp` out 2, `SAXI_rlast` out 1.
  - `SAXI_rvalid` out 1, `SAXI_rready` in 1.

## Operation
- Read FSM states:
  - R_IDLE: `arready`=1. An AR handshake latches id, addr, len, size and burst, clears the beat count, and moves to R_BURST.
  - R_BURST: presents one beat per cycle. A beat advances only on `rvalid && rready`.
  - `rlast`=1 when beat count == len. The rlast handshake returns the FSM to R_IDLE.
- Write FSM states:
  - W_IDLE: `awready`=1, `wready`=0; W data is never accepted before AW. An AW handshake moves to W_DATA.
  - W_DATA: `wready`=1. Each handshake writes the strobed bytes to the current word.
  - The burst ends on the first of `wlast`=1 or beat count == len. The FSM then moves to W_RESP.
  - W_RESP: `bvalid`=1 with the latched `bid`. The `bready` handshake returns the FSM to W_IDLE.
- Address sequencing (next = address of the next beat; step = 1<<size):
  - FIXED (00): address unchanged.
  - INCR (01): next = addr + step.
  - WRAP (10): next = addr + step, wrapping within the aligned (len+1)<<size region; only len ∈ {1,3,7,15} is legal.
  - Reserved burst (11) is treated as INCR.
- Word index = (addr − BASE_ADDR)[MEM_WORDS_LOG2+2:3].
- Narrow transfers (size<3) return the full 64-bit word; the master selects byte lanes.
- Responses:
  - In-window beat: resp OKAY (00).
  - Out-of-window beat: resp DECERR (11), `rdata`=0, write dropped. Evaluated per beat, so a burst crossing the top of the window mixes OKAY and DECERR.
  - `bresp` is the worst of: the beats' responses, and SLVERR (10) when `wlast` disagrees with the beat count (early, late or missing).
- Read/write same word:
  - A write handshaked in cycle N is visible to R beats sampled in cycle N+1 or later.
  - An R beat sampled in the same cycle returns old data.
- Memory contents are not reset.

## Timing
- Reset values:
  - `arready`=0, `awready`=0, `wready`=0.
  - `rvalid`=0, `rlast`=0, `rid`=0, `rresp`=0, `rdata`=0.
  - `bvalid`=0, `bid`=0, `bresp`=0.
- `arready` and `awready` rise in the first cycle after `reset` deasserts.
- Read: AR handshake at cycle T gives first `rvalid` at T+1.
  - With `rready` held high: beat k at T+1+k, `rlast` at T+1+len.
  - `arready` returns at T+2+len; the next AR is accepted no earlier than that cycle.
- `rvalid`/`rdata`/`rlast` are stable while `rready` is low.
- Write: AW handshake at T gives `wready` from T+1.
  - Final W handshake at cycle U gives `bvalid` at U+1.
  - `bvalid` holds until `bready`; the handshake at V gives `awready` at V+1.
- `reset` mid-burst aborts both FSMs immediately. Outputs return to reset values the next cycle, and no B or R beat for the aborted burst is issued.

## Configuration
- `AXI_RAM_LFSR_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to `LFSR_SEED`, advances every cycle.
  - When lfsr[0]=1, `arready`, `awready` and `wready` are forced 0.
  - When lfsr[0]=1, no new R beat is launched; an already-valid beat holds until its handshake, per AXI.
- Undefined: no LFSR logic; timing exactly as in Timing.

## Test plan
- Read at 0x8000_0000, len=0, size=3 after the same address was written 0x1122334455667788 with strb=FF: rdata=0x1122334455667788, rlast=1, rresp=00, at T+1.
- INCR write len=7 at 0x8000_0040 with data i*0x0101…, then read back with rready toggling every other cycle: 8 beats in order, rlast only on beat 7, data stable while stalled.
- WRAP read len=3 at 0x8000_0010: beat addresses 0x10, 0x18, 0x00, 0x08.
- Partial strobe: write 0xFFFF…FF strb=0x0F over a word of zeros; read returns 0x00000000FFFFFFFF.
- Read 0x7FFF_FFF8 len=1 (outside window): two beats with rresp=11, rdata=0. Write with wlast asserted on beat 0 of len=3: bresp=10, B at the cycle after that beat.
- Reset asserted mid-way through an 8-beat read: rvalid=0 the next cycle; arready=1 the first cycle after release; a fresh read completes normally.
